// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error flag
module uart_rx #(
    parameter int BAUD_RATE   = 115_200,
    parameter int CLOCK_SPEED = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;
    localparam int HALF_WIDTH = BAUD_WIDTH / 2;
    localparam int CNT_W      = $clog2(BAUD_WIDTH);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_WIDTH - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_WIDTH - 1);

    if (BAUD_WIDTH < 4) begin : g_baud_check
        $error("uart_rx: BAUD_WIDTH must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_meta_q, rx_s_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_HIGH;
                    end
                end
            end
            // A held-low line (break) must not be mistaken for a fresh start bit.
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
endmodule
